uart_fifo: RTL and testbench

UART_FIFO -- requirements
Module: uart_fifo

---
 rtl/uart_fifo.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_uart_fifo.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo.sv
// Generic synchronous FIFO; flush empties it and wins over push/pop.
// Latency: a pushed entry is visible at pop_dat on the next cycle.
// Backpressure: push_rdy low when full (push ignored); pop_vld low when empty.
module uart_fifo_buf #(
   parameter int DW    = 8,
   parameter int DEPTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push_vld,
   input  logic [DW-1:0] push_dat,
   output logic          push_rdy,
   input  logic          pop_rdy,
   output logic          pop_vld,
   output logic [DW-1:0] pop_dat,
   output logic [7:0]    count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   cnt;
   logic          do_push, do_pop;

   assign push_rdy = (cnt != FULL_CNT);
   assign pop_vld  = (cnt != '0);
   assign pop_dat  = mem[rd_ptr];
   assign do_push  = push_vld & push_rdy;
   assign do_pop   = pop_rdy & pop_vld;
   assign count    = 8'(cnt);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_dat;
   end
endmodule

// UART with TX/RX byte FIFOs behind a small register file.
// Latency: register reads return one cycle after the address; TX starts one cycle after push.
// Backpressure: TXDATA writes to a full FIFO are dropped (tx_drop); RX bytes into a full FIFO are dropped (overrun).
module uart_fifo #(
   parameter int CLK_FREQ   = 50000000,
   parameter int UART_BPS   = 19200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        uart_rx,
   output logic        uart_tx,
   input  logic        wr_en_i,
   input  logic [31:0] wr_addr_i,
   input  logic [31:0] wr_data_i,
   input  logic        rd_en_i,
   input  logic [31:0] rd_addr_i,
   output logic [31:0] rd_data_o,
   output logic        uart_int_flag_o
);
   localparam logic [15:0] RST_BAUD = 16'(CLK_FREQ / UART_BPS);
   localparam logic [4:0] A_CTRL = 5'h00, A_STAT = 5'h04, A_TXD = 5'h08,
                          A_RXD  = 5'h0C, A_BAUD = 5'h10;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

   logic [7:0]  ctrl;
   logic [15:0] baud;
   logic        par_err, frm_err, overrun, tx_drop;
   logic        tx_en, rx_en, par_en, par_odd, stop2, rxie, txie, errie;
   logic        wr_ctrl, wr_stat, wr_txd, wr_baud, rd_rxd, tx_flush, rx_flush;
   logic        unused_bits;

   assign {errie, txie, rxie, stop2, par_odd, par_en, rx_en, tx_en} = ctrl;

   assign wr_ctrl  = wr_en_i && (wr_addr_i[4:0] == A_CTRL);
   assign wr_stat  = wr_en_i && (wr_addr_i[4:0] == A_STAT);
   assign wr_txd   = wr_en_i && (wr_addr_i[4:0] == A_TXD);
   assign wr_baud  = wr_en_i && (wr_addr_i[4:0] == A_BAUD);
   assign rd_rxd   = rd_en_i && (rd_addr_i[4:0] == A_RXD);
   assign tx_flush = wr_ctrl & wr_data_i[8];
   assign rx_flush = wr_ctrl & wr_data_i[9];
   assign unused_bits = ^{wr_addr_i[31:5], rd_addr_i[31:5], wr_data_i[31:16]};

   // ---------------- FIFOs ----------------
   logic       tx_nfull, tx_vld, tx_pop, rx_nfull, rx_vld, rx_push_vld;
   logic [7:0] tx_head, rx_head, tx_count, rx_count, rx_shift;

   uart_fifo_buf #(.DW(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .rst(rst), .flush(tx_flush),
      .push_vld(wr_txd), .push_dat(wr_data_i[7:0]), .push_rdy(tx_nfull),
      .pop_rdy(tx_pop), .pop_vld(tx_vld), .pop_dat(tx_head), .count(tx_count)
   );

   uart_fifo_buf #(.DW(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .rst(rst), .flush(rx_flush),
      .push_vld(rx_push_vld), .push_dat(rx_shift), .push_rdy(rx_nfull),
      .pop_rdy(rd_rxd), .pop_vld(rx_vld), .pop_dat(rx_head), .count(rx_count)
   );

   // ---------------- TX ----------------
   uart_state_t tx_state;
   logic [15:0] tx_cnt, tx_div;
   logic [2:0]  tx_bit;
   logic [7:0]  tx_shift;
   logic        tx_par, tx_par_en_l, tx_stop2_l, tx_stop_idx, tx_done, tx_busy, tx_frame_end;

   assign tx_busy      = (tx_state != IDLE);
   assign tx_done      = (tx_cnt == tx_div - 16'd1);
   assign tx_frame_end = (tx_state == STOP) && tx_done && (!tx_stop2_l || tx_stop_idx);
   // Popping at the last stop clock chains frames with no idle bit in between.
   assign tx_pop = tx_en && tx_vld && !tx_flush && ((tx_state == IDLE) || tx_frame_end);

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state    <= IDLE;
         tx_cnt      <= '0;
         tx_div      <= RST_BAUD;
         tx_bit      <= '0;
         tx_shift    <= '0;
         tx_par      <= 1'b0;
         tx_par_en_l <= 1'b0;
         tx_stop2_l  <= 1'b0;
         tx_stop_idx <= 1'b0;
         uart_tx     <= 1'b1;
      end else if (tx_pop) begin
         tx_state    <= START;
         tx_cnt      <= '0;
         tx_div      <= baud;
         tx_bit      <= '0;
         tx_shift    <= tx_head;
         tx_par      <= (^tx_head) ^ par_odd;
         tx_par_en_l <= par_en;
         tx_stop2_l  <= stop2;
         tx_stop_idx <= 1'b0;
         uart_tx     <= 1'b0;
      end else begin
         tx_cnt <= tx_done ? 16'd0 : tx_cnt + 16'd1;
         case (tx_state)
            IDLE: begin
               tx_cnt  <= '0;
               uart_tx <= 1'b1;
            end
            START: if (tx_done) begin
               tx_state <= DATA;
               uart_tx  <= tx_shift[0];
            end
            DATA: if (tx_done) begin
               if (tx_bit == 3'd7) begin
                  tx_state <= tx_par_en_l ? PARITY : STOP;
                  uart_tx  <= tx_par_en_l ? tx_par : 1'b1;
               end else begin
                  tx_bit   <= tx_bit + 3'd1;
                  tx_shift <= {1'b0, tx_shift[7:1]};
                  uart_tx  <= tx_shift[1];
               end
            end
            PARITY: if (tx_done) begin
               tx_state <= STOP;
               uart_tx  <= 1'b1;
            end
            STOP: if (tx_done) begin
               if (tx_stop2_l && !tx_stop_idx) tx_stop_idx <= 1'b1;
               else                            tx_state    <= IDLE;
               uart_tx <= 1'b1;
            end
            default: tx_state <= IDLE;
         endcase
      end
   end

   // ---------------- RX ----------------
   uart_state_t rx_state;
   logic [15:0] rx_cnt, rx_div;
   logic [2:0]  rx_bit;
   logic        rx_s1, rx_s2, rx_prev, rx_par_en_l, rx_par_odd_l, rx_done;
   logic        rx_perr_p, rx_ferr_p;

   assign rx_done = (rx_cnt == rx_div - 16'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1        <= 1'b1;
         rx_s2        <= 1'b1;
         rx_prev      <= 1'b1;
         rx_state     <= IDLE;
         rx_cnt       <= '0;
         rx_div       <= RST_BAUD;
         rx_bit       <= '0;
         rx_shift     <= '0;
         rx_par_en_l  <= 1'b0;
         rx_par_odd_l <= 1'b0;
         rx_push_vld  <= 1'b0;
         rx_perr_p    <= 1'b0;
         rx_ferr_p    <= 1'b0;
      end else begin
         rx_s1       <= uart_rx;
         rx_s2       <= rx_s1;
         rx_prev     <= rx_s2;
         rx_push_vld <= 1'b0;
         rx_perr_p   <= 1'b0;
         rx_ferr_p   <= 1'b0;
         if (!rx_en) begin
            rx_state <= IDLE;
         end else begin
            rx_cnt <= rx_done ? 16'd0 : rx_cnt + 16'd1;
            case (rx_state)
               IDLE: begin
                  rx_cnt <= '0;
                  if (rx_prev && !rx_s2) begin
                     rx_state     <= START;
                     rx_div       <= baud;
                     rx_par_en_l  <= par_en;
                     rx_par_odd_l <= par_odd;
                  end
               end
               // Mid-start sample; later samples fall a whole bit period apart.
               START: if (rx_cnt == {1'b0, rx_div[15:1]}) begin
                  rx_cnt   <= '0;
                  rx_bit   <= '0;
                  rx_state <= rx_s2 ? IDLE : DATA;
               end
               DATA: if (rx_done) begin
                  rx_shift <= {rx_s2, rx_shift[7:1]};
                  rx_bit   <= rx_bit + 3'd1;
                  if (rx_bit == 3'd7) rx_state <= rx_par_en_l ? PARITY : STOP;
               end
               PARITY: if (rx_done) begin
                  rx_perr_p <= rx_s2 ^ (^rx_shift) ^ rx_par_odd_l;
                  rx_state  <= STOP;
               end
               STOP: if (rx_done) begin
                  rx_push_vld <= 1'b1;
                  rx_ferr_p   <= !rx_s2;
                  rx_state    <= IDLE;
               end
               default: rx_state <= IDLE;
            endcase
         end
      end
   end

   // ---------------- Registers ----------------
   logic [31:0] status, rd_mux;

   assign status = {tx_count, rx_count, 7'h0, tx_drop, overrun, frm_err, par_err,
                    ~rx_nfull, ~rx_vld, tx_busy, ~tx_vld, ~tx_nfull};

   always_comb begin
      rd_mux = '0;
      case (rd_addr_i[4:0])
         A_CTRL:  rd_mux = {24'h0, ctrl};
         A_STAT:  rd_mux = status;
         A_RXD:   rd_mux = rx_vld ? {24'h0, rx_head} : 32'h0;
         A_BAUD:  rd_mux = {16'h0, baud};
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl            <= '0;
         baud            <= RST_BAUD;
         par_err         <= 1'b0;
         frm_err         <= 1'b0;
         overrun         <= 1'b0;
         tx_drop         <= 1'b0;
         rd_data_o       <= '0;
         uart_int_flag_o <= 1'b0;
      end else begin
         if (wr_ctrl) ctrl <= wr_data_i[7:0];
         if (wr_baud) baud <= (wr_data_i[15:0] < 16'd4) ? 16'd4 : wr_data_i[15:0];
         par_err <= (par_err & ~(wr_stat & wr_data_i[5])) | rx_perr_p;
         frm_err <= (frm_err & ~(wr_stat & wr_data_i[6])) | (rx_push_vld & rx_ferr_p);
         overrun <= (overrun & ~(wr_stat & wr_data_i[7])) | (rx_push_vld & ~rx_nfull);
         tx_drop <= (tx_drop & ~(wr_stat & wr_data_i[8])) | (wr_txd & ~tx_nfull);
         rd_data_o       <= rd_mux;
         uart_int_flag_o <= (rxie & rx_vld) | (txie & ~tx_vld & ~tx_busy) |
                            (errie & (par_err | frm_err | overrun));
      end
   end
endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: register table plus serial TX/RX corner sequences.
module tb_uart_fifo;
   localparam int DEPTH = 8;
   localparam int DIV   = 8;

   logic        clk = 1'b0;
   logic        rst, uart_rx, uart_tx, wr_en, rd_en, int_flag, loop_en, rx_drv;
   logic [31:0] wr_addr, wr_data, rd_addr, rd_data, s;
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;
   assign uart_rx = loop_en ? uart_tx : rx_drv;

   uart_fifo #(.CLK_FREQ(50000000), .UART_BPS(19200), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
      .uart_int_flag_o(int_flag)
   );

   typedef struct {
      logic        we;
      logic [31:0] wa;
      logic [31:0] wd;
      logic        re;
      logic [31:0] ra;
      logic        chk;
      logic [31:0] exp;
   } vec_t;
   vec_t vt[$];

   function automatic vec_t mkw(input logic [31:0] a, input logic [31:0] d);
      vec_t v;
      v = '{we: 1'b1, wa: a, wd: d, re: 1'b0, ra: 32'h0, chk: 1'b0, exp: 32'h0};
      return v;
   endfunction

   function automatic vec_t mkr(input logic [31:0] a, input logic [31:0] e);
      vec_t v;
      v = '{we: 1'b0, wa: 32'h0, wd: 32'h0, re: 1'b1, ra: a, chk: 1'b1, exp: e};
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick(1);
      wr_en = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      rd_en = 1'b1; rd_addr = a;
      tick(1);
      d = rd_data;
      rd_en = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] e);
      logic [31:0] d;
      rd(a, d);
      check(name, d, e);
   endtask

   // bits[0] is the start bit; each bit must hold for exactly DIV clocks.
   task automatic check_wave(input string name, input logic [15:0] bits, input int nbits);
      logic got_low, busy_last;
      int   bad;
      got_low = 1'b0;
      busy_last = 1'b0;
      rd_en = 1'b1; rd_addr = 32'h4;
      for (int i = 0; i < 400 && !got_low; i++) begin
         tick(1);
         if (uart_tx === 1'b0) got_low = 1'b1;
      end
      check({name, " start seen"}, 32'(got_low), 32'h1);
      if (got_low) begin
         for (int b = 0; b < nbits; b++) begin
            bad = 0;
            for (int c = 0; c < DIV; c++) begin
               if (b != 0 || c != 0) tick(1);
               if (uart_tx !== bits[b]) bad++;
               if (b == nbits - 1 && c == DIV - 1) busy_last = rd_data[2];
            end
            check($sformatf("%s bit%0d bad clocks", name, b), 32'(bad), 32'h0);
         end
         check({name, " busy in last stop clock"}, 32'(busy_last), 32'h1);
         tick(2);
         check({name, " busy/empty after"}, {30'h0, rd_data[2:1]}, 32'h1);
      end
      rd_en = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic use_par, input logic par_v,
                          input logic stop_v);
      rx_drv = 1'b0;
      tick(DIV);
      for (int i = 0; i < 8; i++) begin
         rx_drv = b[i];
         tick(DIV);
      end
      if (use_par) begin
         rx_drv = par_v;
         tick(DIV);
      end
      rx_drv = stop_v;
      tick(DIV);
      rx_drv = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic got;
      int   lows;
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
      rx_drv = 1'b1; loop_en = 1'b0;
      tick(3);
      check("reset uart_tx", 32'(uart_tx), 32'h1);
      check("reset rd_data", rd_data, 32'h0);
      check("reset int", 32'(int_flag), 32'h0);
      rst = 1'b0;

      // Register file table
      vt.push_back(mkr(32'h00, 32'h0));
      vt.push_back(mkr(32'h10, 32'd2604));
      vt.push_back(mkr(32'h04, 32'h0000_000A));
      vt.push_back(mkw(32'h10, 32'h2));
      vt.push_back(mkr(32'h10, 32'h4));
      vt.push_back(mkw(32'h10, 32'h0001_2345));
      vt.push_back(mkr(32'h10, 32'h2345));
      vt.push_back(mkw(32'h10, 32'h8));
      vt.push_back(mkr(32'h10, 32'h8));
      vt.push_back(mkw(32'h00, 32'h3E4));
      vt.push_back(mkr(32'h00, 32'hE4));
      vt.push_back(mkw(32'h14, 32'hFFFF_FFFF));
      vt.push_back(mkr(32'h14, 32'h0));
      vt.push_back(mkr(32'h08, 32'h0));
      vt.push_back(mkr(32'h0C, 32'h0));
      vt.push_back(mkw(32'h00, 32'h0));
      vt.push_back(mkr(32'h00, 32'h0));
      for (int i = 0; i < vt.size(); i++) begin
         wr_en = vt[i].we; wr_addr = vt[i].wa; wr_data = vt[i].wd;
         rd_en = vt[i].re; rd_addr = vt[i].ra;
         tick(1);
         if (vt[i].chk) check($sformatf("vec%0d", i), rd_data, vt[i].exp);
         wr_en = 1'b0; rd_en = 1'b0;
      end

      // TX framing
      wr(32'h00, 32'h1);
      wr(32'h08, 32'hA5);
      check_wave("tx_a5", {6'b0, 1'b1, 8'hA5, 1'b0}, 10);
      wr(32'h00, 32'h1D);
      wr(32'h08, 32'h03);
      check_wave("tx_par_stop2", {4'b0, 2'b11, 1'b1, 8'h03, 1'b0}, 12);

      // TX overflow, tx_drop W1C, tx_flush
      wr(32'h00, 32'h0);
      for (int i = 0; i <= DEPTH; i++) wr(32'h08, 32'h60 + 32'(i));
      rd_chk("tx full+drop", 32'h04, 32'h0800_0109);
      wr(32'h04, 32'h100);
      rd_chk("tx_drop cleared", 32'h04, 32'h0800_0009);
      wr(32'h00, 32'h100);
      rd_chk("tx flushed", 32'h04, 32'h0000_000A);
      rd_chk("flush self-clear", 32'h00, 32'h0);

      // Loopback
      loop_en = 1'b1;
      wr(32'h00, 32'h3);
      wr(32'h08, 32'h11);
      wr(32'h08, 32'h22);
      wr(32'h08, 32'h33);
      got = 1'b0;
      for (int i = 0; i < 800 && !got; i++) begin
         rd(32'h04, s);
         if (s[23:16] == 8'd3) got = 1'b1;
      end
      check("loop rx_count", {24'h0, s[23:16]}, 32'h3);
      wr(32'h00, 32'h23);
      tick(2);
      check("rxie int set", 32'(int_flag), 32'h1);
      rd_chk("loop rd0", 32'h0C, 32'h11);
      rd_chk("loop rd1", 32'h0C, 32'h22);
      rd_chk("loop rd2", 32'h0C, 32'h33);
      rd_chk("loop rd empty", 32'h0C, 32'h0);
      tick(2);
      check("rxie int clear", 32'(int_flag), 32'h0);
      rd_chk("loop status", 32'h04, 32'h0000_000A);
      loop_en = 1'b0;
      wr(32'h00, 32'h2);

      // RX overrun
      for (int i = 0; i <= DEPTH; i++) send_rx(8'(8'h40 + i), 1'b0, 1'b0, 1'b1);
      tick(5);
      rd_chk("rx full+overrun", 32'h04, 32'h0008_0092);
      wr(32'h04, 32'h80);
      rd_chk("overrun cleared", 32'h04, 32'h0008_0012);
      for (int i = 0; i < DEPTH; i++)
         rd_chk($sformatf("overrun rd%0d", i), 32'h0C, 32'h40 + 32'(i));
      rd_chk("overrun drained", 32'h0C, 32'h0);

      // Framing error, then a glitch
      send_rx(8'h5A, 1'b0, 1'b0, 1'b0);
      tick(5);
      rd_chk("frm_err status", 32'h04, 32'h0001_0042);
      rd_chk("frm_err byte", 32'h0C, 32'h5A);
      wr(32'h04, 32'h40);
      rx_drv = 1'b0;
      tick(1);
      rx_drv = 1'b1;
      tick(30);
      rd_chk("glitch ignored", 32'h04, 32'h0000_000A);

      // Parity
      wr(32'h00, 32'h6);
      send_rx(8'h01, 1'b1, 1'b0, 1'b1);
      tick(5);
      rd_chk("par_err status", 32'h04, 32'h0001_0022);
      rd_chk("par_err byte", 32'h0C, 32'h01);
      wr(32'h00, 32'h86);
      tick(2);
      check("errie int set", 32'(int_flag), 32'h1);
      wr(32'h04, 32'h20);
      tick(2);
      check("errie int clear", 32'(int_flag), 32'h0);
      send_rx(8'h03, 1'b1, 1'b0, 1'b1);
      tick(5);
      rd_chk("good parity status", 32'h04, 32'h0001_0002);
      rd_chk("good parity byte", 32'h0C, 32'h03);

      // Reset during a TX frame
      wr(32'h00, 32'h1);
      wr(32'h08, 32'h00);
      wr(32'h08, 32'h7E);
      got = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
         tick(1);
         if (uart_tx === 1'b0) got = 1'b1;
      end
      check("rst frame started", 32'(got), 32'h1);
      tick(20);
      check("mid-frame low", 32'(uart_tx), 32'h0);
      rst = 1'b1;
      tick(1);
      check("rst uart_tx", 32'(uart_tx), 32'h1);
      check("rst rd_data", rd_data, 32'h0);
      check("rst int", 32'(int_flag), 32'h0);
      rst = 1'b0;
      rd_chk("rst status", 32'h04, 32'h0000_000A);
      rd_chk("rst ctrl", 32'h00, 32'h0);
      rd_chk("rst baud", 32'h10, 32'd2604);
      lows = 0;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         if (uart_tx !== 1'b1) lows++;
      end
      check("idle after rst", 32'(lows), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
